// File: rtl/cpu_bus_sequencer_if.sv
// CPU-side bus bundle: clock enable, stretched reset, RDY, synchronised interrupts
// and the program counter fed back from the core.
interface cpu_bus_sequencer_if;
    logic        cpu_enable;
    logic        cpu_reset;
    logic        cpu_ready;
    logic        cpu_irq_n;
    logic        cpu_nmi_n;
    logic [15:0] pc_monitor;

    modport master (
        output cpu_enable,
        output cpu_reset,
        output cpu_ready,
        output cpu_irq_n,
        output cpu_nmi_n,
        input  pc_monitor
    );

    modport slave (
        input  cpu_enable,
        input  cpu_reset,
        input  cpu_ready,
        input  cpu_irq_n,
        input  cpu_nmi_n,
        output pc_monitor
    );
endinterface

// File: rtl/cpu_bus_sequencer.sv
// CPU bus sequencer: clock-enable divider, reset stretcher, wait-state/pause RDY
// generation, input synchronisers and a PC history trace buffer.
module cpu_bus_sequencer #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned TRACE_DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pause,
    input  logic                           irq_n,
    input  logic                           nmi_n,
    input  logic                           trace_freeze,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [15:0]                    trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    cpu_bus_sequencer_if.master            cpu_bus
);

    localparam int unsigned AW = $clog2(TRACE_DEPTH);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DivLast     = DW'(CLK_DIV - 1);
    localparam logic [7:0]    StretchLast = 8'(RESET_CYCLES - 1);
    localparam logic [3:0]    WaitLoad    = 4'(WAIT_STATES);
    localparam logic [AW:0]   TraceFull   = (AW + 1)'(TRACE_DEPTH);

    logic [DW-1:0] div_q, div_d;
    logic          en_q;
    logic          cres_q;
    logic [7:0]    stretch_q;
    logic [3:0]    wait_q, wait_d;
    logic          ready_q;

    logic          pause_s1_q, pause_s2_q;
    logic          irq_s1_q, irq_s2_q;
    logic          nmi_s1_q, nmi_s2_q;

    logic [15:0]   mem [TRACE_DEPTH];
    logic [15:0]   last_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [15:0]   tpc_q;
    logic          capture;

    always_comb begin
        div_d = (div_q == DivLast) ? '0 : div_q + DW'(1);

        // Reset stretch pins the wait counter; otherwise it only moves on enable pulses.
        wait_d = wait_q;
        if (cres_q) begin
            wait_d = '0;
        end else if (en_q) begin
            if (ready_q) begin
                wait_d = WaitLoad;
            end else if (wait_q != 4'd0) begin
                wait_d = wait_q - 4'd1;
            end
        end

        capture = en_q && ready_q && !cres_q && !trace_freeze &&
                  ((cpu_bus.pc_monitor != last_q) || (count_q == '0));

        rd_ptr = wp_q - AW'(1) - trace_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            en_q       <= 1'b0;
            cres_q     <= 1'b1;
            stretch_q  <= '0;
            wait_q     <= '0;
            ready_q    <= 1'b1;
            pause_s1_q <= 1'b0;
            pause_s2_q <= 1'b0;
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
            nmi_s1_q   <= 1'b1;
            nmi_s2_q   <= 1'b1;
            wp_q       <= '0;
            count_q    <= '0;
            tpc_q      <= '0;
        end else begin
            div_q <= div_d;
            // Registered from the next count so the pulse coincides with div_q == CLK_DIV-1.
            en_q  <= (div_d == DivLast);

            if (cres_q && en_q) begin
                stretch_q <= stretch_q + 8'd1;
                if (stretch_q == StretchLast) begin
                    cres_q <= 1'b0;
                end
            end

            wait_q     <= wait_d;
            // pause_s1_q is what pause_s2_q becomes, so RDY tracks the second stage exactly.
            ready_q    <= (wait_d == 4'd0) && !pause_s1_q;

            pause_s1_q <= pause;
            pause_s2_q <= pause_s1_q;
            irq_s1_q   <= irq_n;
            irq_s2_q   <= irq_s1_q;
            nmi_s1_q   <= nmi_n;
            nmi_s2_q   <= nmi_s1_q;

            if (capture) begin
                wp_q <= wp_q + AW'(1);
                if (count_q != TraceFull) begin
                    count_q <= count_q + (AW + 1)'(1);
                end
            end

            // Reads see the pre-write contents when the same entry is captured this clock.
            tpc_q <= ({1'b0, trace_idx} >= count_q) ? 16'h0000 : mem[rd_ptr];
        end
    end

    // Trace storage is deliberately not reset; count_q alone defines validity.
    always_ff @(posedge clk) begin
        if (capture && !reset) begin
            mem[wp_q] <= cpu_bus.pc_monitor;
            last_q    <= cpu_bus.pc_monitor;
        end
    end

    assign cpu_bus.cpu_enable = en_q;
    assign cpu_bus.cpu_reset  = cres_q;
    assign cpu_bus.cpu_ready  = ready_q;
    assign cpu_bus.cpu_irq_n  = irq_s2_q;
    assign cpu_bus.cpu_nmi_n  = nmi_s2_q;
    assign trace_pc           = tpc_q;
    assign trace_count        = count_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: two instances (default and CLK_DIV=2/WAIT_STATES=2/
// TRACE_DEPTH=4) checked against a cycle-level behavioural model.
module tb_cpu_bus_sequencer;

    localparam int CD0 = 4, WS0 = 0, RC0 = 8, TD0 = 16;
    localparam int CD1 = 2, WS1 = 2, RC1 = 3, TD1 = 4;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        pause_in [2];
    logic        irq_in   [2];
    logic        nmi_in   [2];
    logic        frz      [2];
    logic [15:0] pc_in    [2];
    logic [3:0]  idx0;
    logic [1:0]  idx1;
    logic [15:0] tpc0, tpc1;
    logic [4:0]  cnt0;
    logic [2:0]  cnt1;

    cpu_bus_sequencer_if bus0 ();
    cpu_bus_sequencer_if bus1 ();
    assign bus0.pc_monitor = pc_in[0];
    assign bus1.pc_monitor = pc_in[1];

    cpu_bus_sequencer #(
        .CLK_DIV(CD0), .WAIT_STATES(WS0), .RESET_CYCLES(RC0), .TRACE_DEPTH(TD0)
    ) dut0 (
        .clk(clk), .reset(rst[0]), .pause(pause_in[0]), .irq_n(irq_in[0]), .nmi_n(nmi_in[0]),
        .trace_freeze(frz[0]), .trace_idx(idx0), .trace_pc(tpc0), .trace_count(cnt0),
        .cpu_bus(bus0)
    );

    cpu_bus_sequencer #(
        .CLK_DIV(CD1), .WAIT_STATES(WS1), .RESET_CYCLES(RC1), .TRACE_DEPTH(TD1)
    ) dut1 (
        .clk(clk), .reset(rst[1]), .pause(pause_in[1]), .irq_n(irq_in[1]), .nmi_n(nmi_in[1]),
        .trace_freeze(frz[1]), .trace_idx(idx1), .trace_pc(tpc1), .trace_count(cnt1),
        .cpu_bus(bus1)
    );

    // Reference model state
    int          t_m [2], pulses [2], wait_m [2];
    bit          in_rst [2];
    bit          s1p [2], s2p [2], s1i [2], s2i [2], s1n [2], s2n [2];
    bit          exp_en [2], exp_cres [2], exp_rdy [2];
    logic [15:0] exp_tpc [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_step(input int d);
        int          cd, ws, rc, td, idx, qs;
        logic [15:0] pc, head;
        bit          cap;
        cd   = (d == 0) ? CD0 : CD1;
        ws   = (d == 0) ? WS0 : WS1;
        rc   = (d == 0) ? RC0 : RC1;
        td   = (d == 0) ? TD0 : TD1;
        qs   = (d == 0) ? q0.size() : q1.size();
        head = 16'h0000;
        if (qs > 0) head = (d == 0) ? q0[0] : q1[0];
        if (rst[d]) begin
            in_rst[d] = 1; t_m[d] = 0; pulses[d] = 0; wait_m[d] = 0;
            s1p[d] = 0; s2p[d] = 0; s1i[d] = 1; s2i[d] = 1; s1n[d] = 1; s2n[d] = 1;
            exp_tpc[d] = 16'h0000;
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            idx = (d == 0) ? int'(idx0) : int'(idx1);
            if (idx < qs) exp_tpc[d] = (d == 0) ? q0[idx] : q1[idx];
            else          exp_tpc[d] = 16'h0000;
            pc  = pc_in[d];
            cap = exp_en[d] && exp_rdy[d] && !exp_cres[d] && !frz[d] && (qs == 0 || pc != head);
            if (cap) begin
                if (d == 0) begin
                    q0.push_front(pc);
                    if (q0.size() > td) void'(q0.pop_back());
                end else begin
                    q1.push_front(pc);
                    if (q1.size() > td) void'(q1.pop_back());
                end
            end
            if (exp_cres[d])     wait_m[d] = 0;
            else if (exp_en[d]) begin
                if (exp_rdy[d])          wait_m[d] = ws;
                else if (wait_m[d] > 0)  wait_m[d] = wait_m[d] - 1;
            end
            if (exp_en[d]) pulses[d] = pulses[d] + 1;
            in_rst[d] = 0;
            t_m[d]    = t_m[d] + 1;
            s2p[d] = s1p[d]; s1p[d] = pause_in[d];
            s2i[d] = s1i[d]; s1i[d] = irq_in[d];
            s2n[d] = s1n[d]; s1n[d] = nmi_in[d];
        end
        exp_en[d]   = !in_rst[d] && ((t_m[d] % cd) == (cd - 1));
        exp_cres[d] = in_rst[d] || (pulses[d] < rc);
        exp_rdy[d]  = (wait_m[d] == 0) && !s2p[d];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; pause_in[d] = 1'b1; irq_in[d] = 1'b0; nmi_in[d] = 1'b0;
            frz[d] = 1'b0; pc_in[d] = 16'h0000;
        end
        idx0 = '0; idx1 = '0;
        repeat (3) tick();
        n_checks++; if (bus0.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en0: got %b expected 0", bus0.cpu_enable); end
        n_checks++; if (bus0.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cres0: got %b expected 1", bus0.cpu_reset); end
        n_checks++; if (bus0.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0: got %b expected 1", bus0.cpu_ready); end
        n_checks++; if (bus0.cpu_irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq0: got %b expected 1", bus0.cpu_irq_n); end
        n_checks++; if (bus0.cpu_nmi_n !== 1'b1) begin n_fail++; $display("FAIL reset_nmi0: got %b expected 1", bus0.cpu_nmi_n); end
        n_checks++; if (tpc0 !== 16'h0000) begin n_fail++; $display("FAIL reset_tpc0: got %h expected 0000", tpc0); end
        n_checks++; if (cnt0 !== 5'd0) begin n_fail++; $display("FAIL reset_cnt0: got %0d expected 0", cnt0); end
        n_checks++; if (bus1.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_en1: got %b expected 0", bus1.cpu_enable); end
        n_checks++; if (bus1.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cres1: got %b expected 1", bus1.cpu_reset); end
        n_checks++; if (bus1.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1: got %b expected 1", bus1.cpu_ready); end
        n_checks++; if (bus1.cpu_irq_n !== 1'b1) begin n_fail++; $display("FAIL reset_irq1: got %b expected 1", bus1.cpu_irq_n); end
        n_checks++; if (bus1.cpu_nmi_n !== 1'b1) begin n_fail++; $display("FAIL reset_nmi1: got %b expected 1", bus1.cpu_nmi_n); end
        n_checks++; if (tpc1 !== 16'h0000) begin n_fail++; $display("FAIL reset_tpc1: got %h expected 0000", tpc1); end
        n_checks++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d expected 0", cnt1); end
        for (int d = 0; d < 2; d++) begin
            pause_in[d] = 1'b0; irq_in[d] = 1'b1; nmi_in[d] = 1'b1;
        end
    endtask

    task automatic test_divider_stretch();
        bit e_en, e_cr;
        rst[0] = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            e_en = (k % CD0) == (CD0 - 1);
            e_cr = k <= (RC0 * CD0 - 1);
            n_checks++; if (bus0.cpu_enable !== e_en) begin n_fail++; $display("FAIL divider_en k=%0d: got %b expected %b", k, bus0.cpu_enable, e_en); end
            n_checks++; if (bus0.cpu_reset !== e_cr) begin n_fail++; $display("FAIL stretch_cres k=%0d: got %b expected %b", k, bus0.cpu_reset, e_cr); end
            n_checks++; if (bus0.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL ready_high k=%0d: got %b expected 1", k, bus0.cpu_ready); end
        end
    endtask

    task automatic test_sync();
        for (int k = 0; k < 40; k++) begin
            irq_in[0] = 1'($urandom_range(0, 1));
            nmi_in[0] = 1'($urandom_range(0, 1));
            tick();
            n_checks++; if (bus0.cpu_irq_n !== s2i[0]) begin n_fail++; $display("FAIL sync_irq k=%0d: got %b expected %b", k, bus0.cpu_irq_n, s2i[0]); end
            n_checks++; if (bus0.cpu_nmi_n !== s2n[0]) begin n_fail++; $display("FAIL sync_nmi k=%0d: got %b expected %b", k, bus0.cpu_nmi_n, s2n[0]); end
        end
        irq_in[0] = 1'b1; nmi_in[0] = 1'b1;
    endtask

    task automatic test_trace_random();
        for (int k = 0; k < 240; k++) begin
            pc_in[0] = 16'h1000 + 16'($urandom_range(0, 7));
            idx0     = 4'($urandom_range(0, 15));
            frz[0]   = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++; if (tpc0 !== exp_tpc[0]) begin n_fail++; $display("FAIL trace_pc k=%0d idx=%0d: got %h expected %h", k, idx0, tpc0, exp_tpc[0]); end
            n_checks++; if (cnt0 !== 5'(q0.size())) begin n_fail++; $display("FAIL trace_count k=%0d: got %0d expected %0d", k, cnt0, q0.size()); end
        end
        frz[0] = 1'b0;
    endtask

    task automatic test_freeze();
        frz[0] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            pc_in[0] = 16'($urandom);
            idx0     = 4'($urandom_range(0, 15));
            tick();
            n_checks++; if (cnt0 !== 5'(TD0)) begin n_fail++; $display("FAIL freeze_count k=%0d: got %0d expected %0d", k, cnt0, TD0); end
            n_checks++; if (tpc0 !== exp_tpc[0]) begin n_fail++; $display("FAIL freeze_pc k=%0d: got %h expected %h", k, tpc0, exp_tpc[0]); end
            n_checks++; if (bus0.cpu_enable !== exp_en[0]) begin n_fail++; $display("FAIL freeze_en k=%0d: got %b expected %b", k, bus0.cpu_enable, exp_en[0]); end
        end
        frz[0] = 1'b0;
    endtask

    task automatic test_wait_pattern();
        int np;
        np = 0;
        rst[1] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_checks++; if (bus1.cpu_enable !== exp_en[1]) begin n_fail++; $display("FAIL wait_en k=%0d: got %b expected %b", k, bus1.cpu_enable, exp_en[1]); end
            n_checks++; if (bus1.cpu_reset !== exp_cres[1]) begin n_fail++; $display("FAIL wait_cres k=%0d: got %b expected %b", k, bus1.cpu_reset, exp_cres[1]); end
            n_checks++; if (bus1.cpu_ready !== exp_rdy[1]) begin n_fail++; $display("FAIL wait_rdy k=%0d: got %b expected %b", k, bus1.cpu_ready, exp_rdy[1]); end
            if (bus1.cpu_enable === 1'b1 && bus1.cpu_reset === 1'b0) begin
                n_checks++;
                if (bus1.cpu_ready !== ((np % 3) == 0)) begin
                    n_fail++; $display("FAIL wait_pattern pulse=%0d: got %b expected %b", np, bus1.cpu_ready, (np % 3) == 0);
                end
                np++;
            end
        end
    endtask

    task automatic test_pause();
        int hold;
        hold = 0;
        for (int k = 0; k < 160; k++) begin
            if (hold == 0) begin
                pause_in[1] = 1'($urandom_range(0, 1));
                hold        = $urandom_range(1, 8);
            end
            hold--;
            tick();
            n_checks++; if (bus1.cpu_ready !== exp_rdy[1]) begin n_fail++; $display("FAIL pause_rdy k=%0d: got %b expected %b", k, bus1.cpu_ready, exp_rdy[1]); end
            n_checks++; if (bus1.cpu_enable !== exp_en[1]) begin n_fail++; $display("FAIL pause_en k=%0d: got %b expected %b", k, bus1.cpu_enable, exp_en[1]); end
        end
        pause_in[1] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_trace_seq();
        logic [15:0] seq [6];
        logic [15:0] rd  [4];
        bit          done, elig;
        seq[0] = 16'h0100; seq[1] = 16'h0100; seq[2] = 16'h0101;
        seq[3] = 16'h0102; seq[4] = 16'h0103; seq[5] = 16'h0104;
        rd[0] = 16'h0104; rd[1] = 16'h0103; rd[2] = 16'h0102; rd[3] = 16'h0101;
        rst[1] = 1'b1; pause_in[1] = 1'b0; frz[1] = 1'b0; idx1 = 2'd0;
        repeat (2) tick();
        rst[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pc_in[1] = seq[k];
            done     = 1'b0;
            for (int w = 0; w < 40 && !done; w++) begin
                elig = exp_en[1] && exp_rdy[1] && !exp_cres[1];
                tick();
                n_checks++; if (tpc1 !== exp_tpc[1]) begin n_fail++; $display("FAIL seq_pc k=%0d: got %h expected %h", k, tpc1, exp_tpc[1]); end
                done = elig;
            end
            n_checks++; if (!done) begin n_fail++; $display("FAIL seq_timeout k=%0d: got no ready pulse expected one within 40 clocks", k); end
            if (k == 0) begin
                idx1 = 2'd2;
                tick();
                n_checks++; if (cnt1 !== 3'd1) begin n_fail++; $display("FAIL seq_count1: got %0d expected 1", cnt1); end
                n_checks++; if (tpc1 !== 16'h0000) begin n_fail++; $display("FAIL seq_idx_beyond: got %h expected 0000", tpc1); end
            end
        end
        n_checks++; if (cnt1 !== 3'd4) begin n_fail++; $display("FAIL seq_count_full: got %0d expected 4", cnt1); end
        for (int i = 0; i < 4; i++) begin
            idx1 = 2'(i);
            tick();
            n_checks++; if (tpc1 !== rd[i]) begin n_fail++; $display("FAIL seq_read idx=%0d: got %h expected %h", i, tpc1, rd[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int w = 0; w < 30 && !found; w++) begin
            tick();
            found = (wait_m[1] != 0);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midreset_setup: got no wait sequence expected one within 30 clocks"); end
        rst[1] = 1'b1;
        tick();
        n_checks++; if (bus1.cpu_enable !== 1'b0) begin n_fail++; $display("FAIL midreset_en: got %b expected 0", bus1.cpu_enable); end
        n_checks++; if (bus1.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_cres: got %b expected 1", bus1.cpu_reset); end
        n_checks++; if (bus1.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_rdy: got %b expected 1", bus1.cpu_ready); end
        n_checks++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL midreset_cnt: got %0d expected 0", cnt1); end
        rst[1] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            n_checks++; if (bus1.cpu_enable !== exp_en[1]) begin n_fail++; $display("FAIL restart_en k=%0d: got %b expected %b", k, bus1.cpu_enable, exp_en[1]); end
            n_checks++; if (bus1.cpu_reset !== exp_cres[1]) begin n_fail++; $display("FAIL restart_cres k=%0d: got %b expected %b", k, bus1.cpu_reset, exp_cres[1]); end
            n_checks++; if (bus1.cpu_ready !== exp_rdy[1]) begin n_fail++; $display("FAIL restart_rdy k=%0d: got %b expected %b", k, bus1.cpu_ready, exp_rdy[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_divider_stretch();
        test_sync();
        test_trace_random();
        test_freeze();
        test_wait_pattern();
        test_pause();
        test_trace_seq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_sequencer.md
CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4, means system clocks per CPU enable pulse; legal range 1..256.
REQ-002 Parameter WAIT_STATES, default 0, means extra enable pulses inserted after every completed CPU bus cycle; legal range 0..15.
REQ-003 Parameter RESET_CYCLES, default 8, means enable pulses cpu_reset stays high after reset falls; legal range 1..255.
REQ-004 Parameter TRACE_DEPTH, default 16, means PC history entries; power of two, 2..256.
REQ-005 Port clk, input, 1, is the single system clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1, is the synchronous active-high reset.
REQ-007 Port pause, input, 1, is an asynchronous request to hold the CPU; it is synchronised internally.
REQ-008 Port irq_n, input, 1, is the asynchronous active-low interrupt request.
REQ-009 Port nmi_n, input, 1, is the asynchronous active-low non-maskable interrupt.
REQ-010 Port pc_monitor, input, 16, is the CPU program counter.
REQ-011 Port trace_freeze, input, 1, stops trace capture while high.
REQ-012 Port trace_idx, input, log2(TRACE_DEPTH), selects a trace entry; 0 is the newest.
REQ-013 Port cpu_enable, output, 1, is the one-clock CPU clock-enable pulse.
REQ-014 Port cpu_reset, output, 1, is the stretched active-high CPU reset.
REQ-015 Port cpu_ready, output, 1, is the CPU RDY signal.
REQ-016 Ports cpu_irq_n and cpu_nmi_n, outputs, 1 each, are the synchronised irq_n and nmi_n.
REQ-017 Port trace_pc, output, 16, is the selected trace entry.
REQ-018 Port trace_count, output, log2(TRACE_DEPTH)+1, is the number of valid trace entries.

Function
REQ-019 The divider counter shall count 0..CLK_DIV-1 and wrap to 0; cpu_enable shall be high for exactly the one clock in which the counter equals CLK_DIV-1. With CLK_DIV=1, cpu_enable shall be high on every clock out of reset.
REQ-020 cpu_reset shall be high while reset is high, and for RESET_CYCLES further cpu_enable pulses after reset falls. It shall fall in the clock after the RESET_CYCLES-th pulse.
REQ-021 pause, irq_n and nmi_n shall each pass through a two-flop synchroniser; cpu_irq_n and cpu_nmi_n shall be the second-stage values, with 2-clock latency.
REQ-022 The wait counter (4 bits) shall load WAIT_STATES on each cpu_enable pulse in which cpu_ready=1 and cpu_reset=0.
REQ-023 The wait counter shall decrement on each cpu_enable pulse while it is nonzero; it shall be held at 0 while cpu_reset=1.
REQ-024 cpu_ready shall be registered and shall equal (wait counter==0) AND NOT synchronised pause.
REQ-025 With WAIT_STATES=0 and pause low, cpu_ready shall stay continuously high.
REQ-026 A pause that becomes active while the wait counter is nonzero shall keep cpu_ready low after the counter reaches 0, until the synchronised pause clears.
REQ-027 A trace capture shall occur on a cpu_enable pulse in which all of the following hold: cpu_ready=1, cpu_reset=0, trace_freeze=0, and pc_monitor differs from the last captured value or trace_count=0.
REQ-028 A capture shall write pc_monitor at the write pointer and then increment the pointer modulo TRACE_DEPTH; when full, the oldest entry shall be overwritten.
REQ-029 trace_count shall increment on each capture and saturate at TRACE_DEPTH.
REQ-030 trace_pc shall be registered, with 1-clock latency, and shall equal the entry at (write pointer - 1 - trace_idx) mod TRACE_DEPTH.
REQ-031 When trace_idx >= trace_count, trace_pc shall be 0x0000.
REQ-032 A capture and a readout of the same entry in the same clock shall return the pre-write contents; the new value shall appear on the next read.
REQ-033 trace_freeze shall not affect the divider, reset stretch, or cpu_ready.

Reset
REQ-034 While reset is high, the block shall drive: cpu_enable=0, cpu_reset=1, cpu_ready=1, cpu_irq_n=1, cpu_nmi_n=1, trace_pc=0x0000, trace_count=0.
REQ-035 While reset is high, the divider, wait counter, write pointer and synchroniser stages shall clear; synchroniser stages clear to their inactive values.
REQ-036 Trace storage contents shall not be cleared on reset; trace_count alone defines validity.
REQ-037 Reset asserted mid-wait or mid-stretch shall abort the sequence and restart from REQ-034 on the next clock.

Verification
REQ-038 CLK_DIV=4, reset held 3 clocks then released -> cpu_enable pulses every 4th clock, starting 4 clocks after release; cpu_reset falls the clock after the 8th pulse.
REQ-039 CLK_DIV=2, WAIT_STATES=2, pause low -> cpu_ready pattern is high for 1 enable pulse, then low for 2 pulses, repeating.
REQ-040 irq_n pulled low at clock N -> cpu_irq_n low at clock N+2; pause high during a wait sequence -> cpu_ready stays low until 2 clocks after pause falls.
REQ-041 TRACE_DEPTH=4, pc_monitor sequence 0x0100,0x0100,0x0101,0x0102,0x0103,0x0104 on successive ready pulses -> trace_count=4; trace_idx 0..3 read 0x0104,0x0103,0x0102,0x0101.
REQ-042 trace_freeze high while pc_monitor changes -> trace_count and all entries unchanged; trace_idx=2 with trace_count=1 -> trace_pc=0x0000.
